stk_ram_responder: RTL and testbench

STK_RAM_RESPONDER -- requirements
Module: stk_ram_responder

---
 rtl/stk_ram_pkg.sv | 37 +++
 rtl/stk_ram_if.sv | 38 +++
 rtl/stk_ram_sp.sv | 40 ++++
 rtl/stk_ram_responder.sv | 228 ++++++++++++++++++++++
 tb/tb_stk_ram_responder.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/stk_ram_pkg.sv
// -----------------------------------------------------------------------------
// stk_ram_pkg
//   Shared types and constants for the stack spill RAM responder.
//   - stk_state_e : responder FSM states (IDLE, WR_BURST, RD_BURST)
//   - stk_dir_e   : direction of the last completed burst (RD, WR)
//   - stk_dbg_t   : debug view of the control state, exported by the top
//   - BURST_LEN   : beats per burst; the final beat is the one whose low
//                   address bits equal BURST_LEN-1
// -----------------------------------------------------------------------------
package stk_ram_pkg;

    localparam int BURST_LEN = 4;
    localparam int BEAT_W    = $clog2(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } stk_state_e;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } stk_dir_e;

    typedef struct packed {
        stk_state_e state;
        stk_dir_e   last_dir;
    } stk_dbg_t;

    // A burst ends on the beat addressed at the last slot of its
    // BURST_LEN-aligned group, not after a fixed count of beats.
    function automatic logic is_last_beat(input logic [BEAT_W-1:0] beat);
        return beat == BEAT_W'(BURST_LEN - 1);
    endfunction

endpackage

// File: rtl/stk_ram_if.sv
// -----------------------------------------------------------------------------
// StkRamIf
//   Stack spill interface between a requester (Master) and the RAM
//   responder (Slave).
//   Parameters: DW data width, AW address width.
//   Read  channel : rd_vld, rd_adr  -> ; <- rd_rdy, rd_dat, rd_ack
//   Write channel : wr_vld, wr_adr, wr_dat -> ; <- wr_rdy
//
//   Handshake: a beat transfers in any cycle where vld and rdy are both
//   high at the rising edge. The requester holds vld/adr/dat stable until
//   it sees rdy; the responder may drop rdy at any time and vld never
//   depends on rdy. Read data has no back-pressure: rd_ack/rd_dat appear
//   exactly one cycle after the read beat transfers.
// -----------------------------------------------------------------------------
interface StkRamIf #(
    parameter int DW = 98,
    parameter int AW = 5
);
    logic          rd_vld;
    logic [AW-1:0] rd_adr;
    logic          rd_rdy;
    logic [DW-1:0] rd_dat;
    logic          rd_ack;
    logic          wr_vld;
    logic [AW-1:0] wr_adr;
    logic [DW-1:0] wr_dat;
    logic          wr_rdy;

    modport Slave (
        input  rd_vld, rd_adr, wr_vld, wr_adr, wr_dat,
        output rd_rdy, rd_dat, rd_ack, wr_rdy
    );

    modport Master (
        output rd_vld, rd_adr, wr_vld, wr_adr, wr_dat,
        input  rd_rdy, rd_dat, rd_ack, wr_rdy
    );
endinterface

// File: rtl/stk_ram_sp.sv
// -----------------------------------------------------------------------------
// stk_ram_sp
//   Behavioural single-port RAM with a registered read port.
//   Parameters: W word width, D number of words, AW address width.
//   Ports:
//     clk   input  1   rising-edge clock
//     en    input  1   port enable (one access per cycle)
//     we    input  1   1 = write wdat to adr, 0 = read adr
//     adr   input  AW  word address (must be < D when en=1)
//     wdat  input  W   write data
//     rdat  output W   read data, valid the cycle after a read; holds
//                      its value on cycles without a read
//   Contents are not reset.
// -----------------------------------------------------------------------------
module stk_ram_sp #(
    parameter int W  = 98,
    parameter int D  = 32,
    parameter int AW = $clog2(D > 2 ? D : 2)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] adr,
    input  logic [W-1:0]  wdat,
    output logic [W-1:0]  rdat
);

    logic [W-1:0] mem [D];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[adr] <= wdat;
            end else begin
                rdat <= mem[adr];
            end
        end
    end

endmodule

// File: rtl/stk_ram_responder.sv
// -----------------------------------------------------------------------------
// stk_ram_responder
//   Responder end of the stack spill interface, backed by a single-port RAM.
//   Reads and writes arrive as 4-beat bursts; a burst owns the RAM port
//   until its last beat (low address bits == 3) is accepted. When both
//   directions request in IDLE, the direction opposite the last completed
//   burst wins.
//
//   Parameters: DW data width, DEPTH RAM entries, AW address width.
//   Ports:
//     clk         input   1    rising-edge clock
//     rst_n       input   1    asynchronous active-low reset
//     clear       input   1    synchronous flush of control state
//     stk_ram_if  StkRamIf.Slave  read/write request channels
//     par_err     output  1    parity error pulse, aligned with rd_ack
//     oob_err     output  1    sticky: an out-of-range beat was accepted
//     dbg         output  stk_dbg_t  FSM state and last burst direction
//
//   Build option: define STK_RAM_PARITY_EN to store one even-parity bit per
//   word and check it on every in-range read. Without it the RAM is DW
//   wide and par_err is held low.
// -----------------------------------------------------------------------------
module stk_ram_responder
    import stk_ram_pkg::*;
#(
    parameter int DW    = 98,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH > 2 ? DEPTH : 2)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    StkRamIf.Slave        stk_ram_if,
    output logic          par_err,
    output logic          oob_err,
    output stk_dbg_t      dbg
);

`ifdef STK_RAM_PARITY_EN
    localparam int RW = DW + 1;
`else
    localparam int RW = DW;
`endif
    // Address width actually needed to index DEPTH words.
    localparam int RAW = $clog2(DEPTH > 2 ? DEPTH : 2);
    localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    stk_state_e state_q, state_d;
    stk_dir_e   last_dir_q, last_dir_d;

    logic wr_grant, rd_grant;
    logic wr_acc, rd_acc;
    logic wr_last, rd_last;
    logic wr_oob, rd_oob;

    assign wr_last = is_last_beat(stk_ram_if.wr_adr[BEAT_W-1:0]);
    assign rd_last = is_last_beat(stk_ram_if.rd_adr[BEAT_W-1:0]);
    assign wr_oob  = {1'b0, stk_ram_if.wr_adr} >= DEPTH_LIM;
    assign rd_oob  = {1'b0, stk_ram_if.rd_adr} >= DEPTH_LIM;

    assign wr_acc = stk_ram_if.wr_vld && wr_grant;
    assign rd_acc = stk_ram_if.rd_vld && rd_grant;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_dir_q <= RD;
        end else begin
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
        end
    end

    // Next-state logic. At most one of wr_acc/rd_acc is ever high because
    // the grants below are mutually exclusive.
    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        if (clear) begin
            state_d    = IDLE;
            last_dir_d = RD;
        end else if (wr_acc) begin
            if (wr_last) begin
                state_d    = IDLE;
                last_dir_d = WR;
            end else begin
                state_d = WR_BURST;
            end
        end else if (rd_acc) begin
            if (rd_last) begin
                state_d    = IDLE;
                last_dir_d = RD;
            end else begin
                state_d = RD_BURST;
            end
        end
    end

    // Output logic: the ready grants. In IDLE they follow the valids
    // combinationally so only a requesting side is granted; inside a burst
    // they come from the state alone. A clear cycle grants nothing, so no
    // beat can slip through while control state is being flushed.
    always_comb begin
        wr_grant = 1'b0;
        rd_grant = 1'b0;
        if (!clear) begin
            case (state_q)
                IDLE: begin
                    if (stk_ram_if.wr_vld && stk_ram_if.rd_vld) begin
                        if (last_dir_q == RD) begin
                            wr_grant = 1'b1;
                        end else begin
                            rd_grant = 1'b1;
                        end
                    end else begin
                        wr_grant = stk_ram_if.wr_vld;
                        rd_grant = stk_ram_if.rd_vld;
                    end
                end
                WR_BURST: wr_grant = 1'b1;
                RD_BURST: rd_grant = 1'b1;
                default: begin
                    wr_grant = 1'b0;
                    rd_grant = 1'b0;
                end
            endcase
        end
    end

    assign stk_ram_if.wr_rdy = wr_grant;
    assign stk_ram_if.rd_rdy = rd_grant;

    always_comb begin
        dbg          = '0;
        dbg.state    = state_q;
        dbg.last_dir = last_dir_q;
    end

    // ------------------------------------------------------------------
    // RAM port. Out-of-range beats are still accepted but never reach the
    // array: writes are dropped and reads are answered with zero.
    // ------------------------------------------------------------------
    logic           ram_en, ram_we;
    logic [AW-1:0]  ram_adr_full;
    logic [RAW-1:0] ram_adr;
    logic [RW-1:0]  ram_wdat, ram_rdat;

    assign ram_we       = wr_acc;
    assign ram_en       = (wr_acc && !wr_oob) || (rd_acc && !rd_oob);
    assign ram_adr_full = wr_acc ? stk_ram_if.wr_adr : stk_ram_if.rd_adr;
    assign ram_adr      = ram_adr_full[RAW-1:0];

`ifdef STK_RAM_PARITY_EN
    // Even parity: the stored word including its parity bit XORs to zero.
    assign ram_wdat = {^stk_ram_if.wr_dat, stk_ram_if.wr_dat};
`else
    assign ram_wdat = stk_ram_if.wr_dat;
`endif

    stk_ram_sp #(
        .W  (RW),
        .D  (DEPTH),
        .AW (RAW)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .adr  (ram_adr),
        .wdat (ram_wdat),
        .rdat (ram_rdat)
    );

    // ------------------------------------------------------------------
    // Read response. ack_q marks the cycle after an accepted read;
    // dat_hold_q keeps the last value shown on rd_dat so the bus holds it
    // while no ack is present (the RAM output alone could not, since
    // out-of-range reads never touch it).
    // ------------------------------------------------------------------
    logic          ack_q;
    logic          oob_rd_q;
    logic          oob_err_q;
    logic          rd_ack_c;
    logic [DW-1:0] dat_hold_q;
    logic [DW-1:0] rd_dat_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q      <= 1'b0;
            oob_rd_q   <= 1'b0;
            dat_hold_q <= '0;
            oob_err_q  <= 1'b0;
        end else begin
            ack_q      <= rd_acc;
            oob_rd_q   <= rd_acc && rd_oob;
            dat_hold_q <= rd_dat_c;
            if (clear) begin
                oob_err_q <= 1'b0;
            end else if ((wr_acc && wr_oob) || (rd_acc && rd_oob)) begin
                oob_err_q <= 1'b1;
            end
        end
    end

    // clear also drops an ack already in flight, so a flush in the cycle
    // after a read leaves no response behind.
    always_comb begin
        rd_ack_c = ack_q && !clear;
        rd_dat_c = dat_hold_q;
        if (rd_ack_c) begin
            rd_dat_c = oob_rd_q ? '0 : ram_rdat[DW-1:0];
        end
    end

    assign stk_ram_if.rd_ack = rd_ack_c;
    assign stk_ram_if.rd_dat = rd_dat_c;
    assign oob_err           = oob_err_q;

`ifdef STK_RAM_PARITY_EN
    assign par_err = rd_ack_c && !oob_rd_q && (^ram_rdat);
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_stk_ram_responder.sv
// -----------------------------------------------------------------------------
// tb_stk_ram_responder
//   Directed bench for stk_ram_responder (DW=98, DEPTH=32, AW=6).
//   One table row per clock cycle: inputs driven just after the rising edge,
//   outputs compared on the falling edge. Reset-mid-burst and (with
//   STK_RAM_PARITY_EN) a corrupted-word read are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_stk_ram_responder;
    import stk_ram_pkg::*;

    localparam int DW    = 98;
    localparam int DEPTH = 32;
    localparam int AW    = 6;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    logic clear;
    logic par_err;
    logic oob_err;
    stk_dbg_t dbg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    StkRamIf #(.DW(DW), .AW(AW)) ram_bus ();

    stk_ram_responder #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .stk_ram_if (ram_bus.Slave),
        .par_err    (par_err),
        .oob_err    (oob_err),
        .dbg        (dbg)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic          wv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          rv;
        logic [AW-1:0] ra;
        logic          clr;
        logic          e_wrdy;
        logic          e_rrdy;
        logic          e_ack;
        logic [DW-1:0] e_dat;
        logic          e_oob;
        stk_state_e    e_state;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;
    int   cur_vec  = -1;

    function automatic logic [DW-1:0] dv(input int k);
        return {2'b10, 32'hA000_0000 + k, 64'h0123_4567_89AB_CD00 + {32'h0, k}};
    endfunction

    task automatic add(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic rv, input logic [AW-1:0] ra, input logic clr,
                       input logic e_wrdy, input logic e_rrdy, input logic e_ack,
                       input logic [DW-1:0] e_dat, input logic e_oob, input stk_state_e e_state);
        vec_t v;
        v.wv = wv; v.wa = wa; v.wd = wd; v.rv = rv; v.ra = ra; v.clr = clr;
        v.e_wrdy = e_wrdy; v.e_rrdy = e_rrdy; v.e_ack = e_ack;
        v.e_dat = e_dat; v.e_oob = e_oob; v.e_state = e_state;
        vecs.push_back(v);
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0h expected=%0h", nm, cur_vec, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic rv, input logic [AW-1:0] ra, input logic clr);
        ram_bus.wr_vld = wv;
        ram_bus.wr_adr = wa;
        ram_bus.wr_dat = wd;
        ram_bus.rd_vld = rv;
        ram_bus.rd_adr = ra;
        clear          = clr;
    endtask

    task automatic idle_inputs();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] z;
        z = '0;

        // Writes 0..3, reads 0..3 with back-to-back acks and held data.
        add(0, 0, z,      0, 0, 0,  0, 0, 0, z,      0, IDLE);
        add(1, 0, dv(0),  0, 0, 0,  1, 0, 0, z,      0, IDLE);
        add(1, 1, dv(1),  0, 0, 0,  1, 0, 0, z,      0, WR_BURST);
        add(1, 2, dv(2),  0, 0, 0,  1, 0, 0, z,      0, WR_BURST);
        add(1, 3, dv(3),  0, 0, 0,  1, 0, 0, z,      0, WR_BURST);
        add(0, 0, z,      1, 0, 0,  0, 1, 0, z,      0, IDLE);
        add(0, 0, z,      1, 1, 0,  0, 1, 1, dv(0),  0, RD_BURST);
        add(0, 0, z,      1, 2, 0,  0, 1, 1, dv(1),  0, RD_BURST);
        add(0, 0, z,      1, 3, 0,  0, 1, 1, dv(2),  0, RD_BURST);
        add(0, 0, z,      0, 0, 0,  0, 0, 1, dv(3),  0, IDLE);
        add(0, 0, z,      0, 0, 0,  0, 0, 0, dv(3),  0, IDLE);
        // Both valid after a read burst: write wins, read blocked for the burst.
        add(1, 4, dv(4),  1, 8, 0,  1, 0, 0, dv(3),  0, IDLE);
        add(1, 5, dv(5),  1, 8, 0,  1, 0, 0, dv(3),  0, WR_BURST);
        add(1, 6, dv(6),  1, 8, 0,  1, 0, 0, dv(3),  0, WR_BURST);
        add(1, 7, dv(7),  1, 8, 0,  1, 0, 0, dv(3),  0, WR_BURST);
        // Read right after the write to the same address sees new data.
        add(0, 0, z,      1, 7, 0,  0, 1, 0, dv(3),  0, IDLE);
        add(0, 0, z,      0, 0, 0,  0, 0, 1, dv(7),  0, IDLE);
        // Single-beat write burst, then both valid: read wins after a write.
        add(1, 11, dv(11), 0, 0, 0,  1, 0, 0, dv(7),  0, IDLE);
        add(1, 12, dv(12), 1, 11, 0, 0, 1, 0, dv(7),  0, IDLE);
        add(1, 12, dv(12), 1, 11, 0, 1, 0, 1, dv(11), 0, IDLE);
        add(1, 13, dv(13), 0, 0, 0,  1, 0, 0, dv(11), 0, WR_BURST);
        // clear mid write burst: nothing accepted, FSM back to IDLE.
        add(1, 14, dv(14), 0, 0, 1,  0, 0, 0, dv(11), 0, WR_BURST);
        add(0, 0, z,      0, 0, 0,  0, 0, 0, dv(11), 0, IDLE);
        // clear the cycle after a read: ack dropped, data still readable.
        add(0, 0, z,      1, 4, 0,  0, 1, 0, dv(11), 0, IDLE);
        add(0, 0, z,      0, 0, 1,  0, 0, 0, dv(11), 0, RD_BURST);
        add(0, 0, z,      0, 0, 0,  0, 0, 0, dv(11), 0, IDLE);
        add(0, 0, z,      1, 4, 0,  0, 1, 0, dv(11), 0, IDLE);
        add(0, 0, z,      1, 5, 0,  0, 1, 1, dv(4),  0, RD_BURST);
        add(0, 0, z,      1, 7, 0,  0, 1, 1, dv(5),  0, RD_BURST);
        add(0, 0, z,      0, 0, 0,  0, 0, 1, dv(7),  0, IDLE);
        // Out-of-range write and read, sticky flag, cleared by clear.
        add(1, 32, dv(32), 0, 0, 0,  1, 0, 0, dv(7),  0, IDLE);
        add(1, 35, dv(35), 0, 0, 0,  1, 0, 0, dv(7),  1, WR_BURST);
        add(0, 0, z,      1, 35, 0, 0, 1, 0, dv(7),  1, IDLE);
        add(0, 0, z,      0, 0, 0,  0, 0, 1, z,      1, IDLE);
        add(0, 0, z,      0, 0, 1,  0, 0, 0, z,      1, IDLE);
        add(0, 0, z,      0, 0, 0,  0, 0, 0, z,      0, IDLE);
        // Discarded out-of-range writes did not disturb in-range words.
        add(0, 0, z,      1, 0, 0,  0, 1, 0, z,      0, IDLE);
        add(0, 0, z,      1, 3, 0,  0, 1, 1, dv(0),  0, RD_BURST);
        add(0, 0, z,      0, 0, 0,  0, 0, 1, dv(3),  0, IDLE);

        // ---------- reset ----------
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ack",   ram_bus.rd_ack, 1'b0);
        chk("reset_dat",   ram_bus.rd_dat, z);
        chk("reset_oob",   oob_err, 1'b0);
        chk("reset_par",   par_err, 1'b0);
        chk("reset_state", dbg.state, IDLE);
        chk("reset_dir",   dbg.last_dir, RD);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---------- table ----------
        for (int i = 0; i < vecs.size(); i++) begin
            cur_vec = i;
            drive(vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].rv, vecs[i].ra, vecs[i].clr);
            @(negedge clk);
            chk("wr_rdy",  ram_bus.wr_rdy, vecs[i].e_wrdy);
            chk("rd_rdy",  ram_bus.rd_rdy, vecs[i].e_rrdy);
            chk("rd_ack",  ram_bus.rd_ack, vecs[i].e_ack);
            chk("rd_dat",  ram_bus.rd_dat, vecs[i].e_dat);
            chk("oob_err", oob_err, vecs[i].e_oob);
            chk("par_err", par_err, 1'b0);
            chk("state",   dbg.state, vecs[i].e_state);
            @(posedge clk); #1;
        end
        idle_inputs();

        // ---------- reset in the middle of a write burst ----------
        cur_vec = 100;
        drive(1'b1, AW'(16), dv(16), 1'b0, '0, 1'b0);
        @(negedge clk);
        chk("mid_wr_rdy", ram_bus.wr_rdy, 1'b1);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("mid_state", dbg.state, WR_BURST);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", dbg.state, IDLE);
        chk("mid_rst_dat",   ram_bus.rd_dat, z);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        cur_vec = 101;
        drive(1'b0, '0, '0, 1'b1, AW'(16), 1'b0);
        @(negedge clk);
        chk("post_rst_rd_rdy", ram_bus.rd_rdy, 1'b1);
        chk("post_rst_wr_rdy", ram_bus.wr_rdy, 1'b0);
        chk("post_rst_state",  dbg.state, IDLE);
        @(posedge clk); #1;
        drive(1'b0, '0, '0, 1'b1, AW'(19), 1'b0);
        @(negedge clk);
        chk("post_rst_ack",   ram_bus.rd_ack, 1'b1);
        chk("post_rst_state", dbg.state, RD_BURST);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("post_rst_ack2",  ram_bus.rd_ack, 1'b1);
        chk("post_rst_idle",  dbg.state, IDLE);
        @(posedge clk); #1;

`ifdef STK_RAM_PARITY_EN
        // ---------- corrupted stored word ----------
        cur_vec = 200;
        drive(1'b1, AW'(5), dv(5), 1'b0, '0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, AW'(7), dv(7), 1'b0, '0, 1'b0);
        @(posedge clk); #1;
        idle_inputs();
        dut.u_ram.mem[5] = dut.u_ram.mem[5] ^ (DW + 1)'(8);
        @(posedge clk); #1;
        drive(1'b0, '0, '0, 1'b1, AW'(5), 1'b0);
        @(posedge clk); #1;
        drive(1'b0, '0, '0, 1'b1, AW'(7), 1'b0);
        @(negedge clk);
        chk("par_bad_ack", ram_bus.rd_ack, 1'b1);
        chk("par_bad",     par_err, 1'b1);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("par_good_ack", ram_bus.rd_ack, 1'b1);
        chk("par_good",     par_err, 1'b0);
        chk("par_good_dat", ram_bus.rd_dat, dv(7));
        @(posedge clk); #1;
        @(negedge clk);
        chk("par_idle", par_err, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
